// File: rtl/npc_io_pkg.sv
// Shared constants for the switch-input conditioning slice of the encoder/display design.
package npc_io_pkg;

   localparam int unsigned SW_W                = 8;
   localparam int unsigned NUM_CH              = SW_W + 1;
   localparam int unsigned STABLE_CYCLES_SIM   = 4;
   localparam int unsigned STABLE_CYCLES_BOARD = 1000;

   // Counter must be able to hold STABLE_CYCLES-1 for any legal setting.
   function automatic int unsigned cnt_width(input int unsigned stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/sw_debounce8_debounce_bit.sv
// One debounce channel: 2-flop synchroniser, stability counter and registered output.
module debounce_bit
   import npc_io_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_BOARD
) (
   input  logic clk,
   input  logic rst,
   input  logic d_raw,
   output logic q,
   output logic upd
);

   localparam int unsigned         CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             upd_d;

   // Any sample equal to the held level restarts the count, so bounce never accumulates.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      upd_d    = 1'b0;
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            upd_d    = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         s1_q     <= d_raw;
         s2_q     <= s1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign q   = stable_q;
   assign upd = upd_d;

endmodule

// File: rtl/sw_debounce8.sv
// Conditions eight slide switches plus the enable switch for the priority encoder.
module sw_debounce8
   import npc_io_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_BOARD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SW_W-1:0] sw_raw,
   input  logic            en_raw,
   output logic [SW_W-1:0] x,
   output logic            en,
   output logic            changed
);

   logic [NUM_CH-1:0] raw, q, upd;
   logic              changed_q;

   assign raw = {en_raw, sw_raw};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
         .clk   (clk),
         .rst   (rst),
         .d_raw (raw[i]),
         .q     (q[i]),
         .upd   (upd[i])
      );
   end

   // Registered so the strobe lines up with the cycle the new level first appears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) changed_q <= 1'b0;
      else     changed_q <= |upd;
   end

   assign x       = q[SW_W-1:0];
   assign en      = q[SW_W];
   assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Self-checking bench for sw_debounce8 at STABLE_CYCLES=4 and STABLE_CYCLES=1.
module tb_sw_debounce8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] sw_raw = '0;
   logic       en_raw = 1'b0;
   logic [7:0] x0, x1;
   logic       en0, en1, chg0, chg1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   sw_debounce8 #(.STABLE_CYCLES(4)) dut0 (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .en_raw(en_raw),
      .x(x0), .en(en0), .changed(chg0)
   );

   sw_debounce8 #(.STABLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .en_raw(en_raw),
      .x(x1), .en(en1), .changed(chg1)
   );

   // Reference: a channel flips once its raw level, seen two edges late,
   // has differed from the output on each of the last SC edges.
   int unsigned sc_of [2] = '{4, 1};
   logic [8:0]  hist [2][8];
   logic [8:0]  out_m [2];
   logic        chg_m [2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 8; k++) hist[m][k] = '0;
         out_m[m] = '0;
         chg_m[m] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic [8:0] raw);
      for (int m = 0; m < 2; m++) begin
         logic [8:0] nxt;
         for (int k = 7; k > 0; k--) hist[m][k] = hist[m][k-1];
         hist[m][0] = raw;
         nxt = out_m[m];
         for (int b = 0; b < 9; b++) begin
            bit flip;
            flip = 1'b1;
            for (int k = 2; k <= int'(sc_of[m]) + 1; k++)
               if (hist[m][k][b] == out_m[m][b]) flip = 1'b0;
            if (flip) nxt[b] = ~out_m[m][b];
         end
         chg_m[m] = (nxt != out_m[m]);
         out_m[m] = nxt;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [7:0] sw, input logic e);
      sw_raw = sw;
      en_raw = e;
      @(posedge clk);
      #1;
      model_edge({e, sw});
      chk("x0_model",   32'(x0),   32'(out_m[0][7:0]));
      chk("en0_model",  32'(en0),  32'(out_m[0][8]));
      chk("chg0_model", 32'(chg0), 32'(chg_m[0]));
      chk("x1_model",   32'(x1),   32'(out_m[1][7:0]));
      chk("en1_model",  32'(en1),  32'(out_m[1][8]));
      chk("chg1_model", 32'(chg1), 32'(chg_m[1]));
   endtask

   task automatic do_reset(input logic [7:0] sw, input logic e);
      sw_raw = sw;
      en_raw = e;
      rst    = 1'b1;
      model_reset();
      #1;
      chk("rst_x",   32'(x0),   32'h00);
      chk("rst_en",  32'(en0),  32'h0);
      chk("rst_chg", 32'(chg0), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x_hold",   32'(x0),   32'h00);
      chk("rst_en_hold",  32'(en0),  32'h0);
      chk("rst_chg_hold", 32'(chg0), 32'h0);
      chk("rst_x1_hold",  32'(x1),   32'h00);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [7:0] sw;
      logic       en;
      logic [7:0] exp_x;
      logic       exp_en;
      logic       exp_chg;
   } vec_t;

   vec_t tbl [7];

   initial begin
      tbl[0] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'h81, 1'b0, 8'h81, 1'b0, 1'b1};
      tbl[6] = '{8'h81, 1'b0, 8'h81, 1'b0, 1'b0};

      // Reset with all raw inputs high, then clean step 8'h81.
      do_reset(8'hFF, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].sw, tbl[i].en);
         chk("step_x",   32'(x0),   32'(tbl[i].exp_x));
         chk("step_en",  32'(en0),  32'(tbl[i].exp_en));
         chk("step_chg", 32'(chg0), 32'(tbl[i].exp_chg));
      end

      // Bounce on bit 3 with 3-cycle pulses, then a clean hold.
      for (int i = 0; i < 40; i++) begin
         step(8'h81 | (((i / 3) % 2 == 0) ? 8'h08 : 8'h00), 1'b0);
         chk("bounce_x",   32'(x0),   32'h81);
         chk("bounce_chg", 32'(chg0), 32'h0);
      end
      for (int i = 1; i <= 7; i++) begin
         step(8'h89, 1'b0);
         chk("hold_x3",  32'(x0[3]), (i >= 6) ? 32'h1 : 32'h0);
         chk("hold_chg", 32'(chg0),  (i == 6) ? 32'h1 : 32'h0);
      end

      // Staggered: en rises one cycle after sw[0].
      do_reset(8'h00, 1'b0);
      step(8'h01, 1'b0);
      for (int i = 2; i <= 8; i++) begin
         step(8'h01, 1'b1);
         chk("stag_x0",  32'(x0[0]), (i >= 6) ? 32'h1 : 32'h0);
         chk("stag_en",  32'(en0),   (i >= 7) ? 32'h1 : 32'h0);
         chk("stag_chg", 32'(chg0),  (i == 6 || i == 7) ? 32'h1 : 32'h0);
      end

      // Mid-count reset discards progress.
      do_reset(8'h00, 1'b0);
      repeat (3) step(8'h10, 1'b0);
      chk("mid_x_pre", 32'(x0), 32'h00);
      do_reset(8'h10, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step(8'h10, 1'b0);
         chk("mid_x", 32'(x0), (i == 6) ? 32'h10 : 32'h00);
      end

      // STABLE_CYCLES=1: single one-cycle pulse.
      do_reset(8'h00, 1'b0);
      step(8'h01, 1'b0);
      chk("min_x_e1", 32'(x1), 32'h00);
      step(8'h00, 1'b0);
      chk("min_x_e2", 32'(x1), 32'h00);
      step(8'h00, 1'b0);
      chk("min_x_e3",   32'(x1),   32'h01);
      chk("min_chg_e3", 32'(chg1), 32'h1);
      step(8'h00, 1'b0);
      chk("min_x_e4",   32'(x1),   32'h00);
      chk("min_chg_e4", 32'(chg1), 32'h1);
      step(8'h00, 1'b0);
      chk("min_chg_e5", 32'(chg1), 32'h0);
      chk("min_x0_e5",  32'(x0),   32'h00);

      // Randomised holds of varying length with occasional resets.
      for (int i = 0; i < 80; i++) begin
         logic [8:0] v;
         int unsigned hold;
         v    = 9'($urandom);
         hold = $urandom_range(1, 8);
         if (i % 20 == 19) do_reset(8'($urandom), 1'($urandom));
         for (int j = 0; j < int'(hold); j++) step(v[7:0], v[8]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
